rr_mux8_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8:1 bit-select datapath among eight requesters. It grants one requester at a time and drives the 3-bit mux select and a one-hot grant vector. It captures the selected input bit into a registered output with a valid flag. A per-grant hold limit bounds how long one requester can keep the channel.

---
 rtl/rr_mux8_arbiter.sv | 110 +++++++++++
 tb/tb_rr_mux8_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter that shares one 8:1 bit-select datapath among eight requesters.
// It grants one requester at a time, with a per-grant hold limit.
module rr_mux8_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       last,
  input  logic [7:0] in,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       out,
  output logic       out_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] s_q, s_d;
  logic [7:0] gnt_q, gnt_d;
  logic       out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic [2:0] win;
  logic [2:0] idx;
  logic       xfer;
  logic       release_c;

  // Pick the first requester at or after ptr. Scanning downward lets the nearest one win.
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_q + 3'(k);
      if (req[idx]) win = idx;
    end
  end

  // Decide transfer and release for the current grant.
  always_comb begin
    xfer      = req[s_q];
    release_c = !xfer || last || (cnt_q == CNT_LIMIT);
  end

  // Compute the next state and the next register values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    gnt_d       = gnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          state_d = BUSY;
          s_d     = win;
          gnt_d   = 8'h01 << win;
          cnt_d   = 8'h00;
        end
      end
      BUSY: begin
        if (xfer) begin
          out_d       = in[s_q];
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 8'd1;
        end
        if (release_c) begin
          state_d = IDLE;
          gnt_d   = 8'h00;
          ptr_d   = s_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      cnt_q       <= 8'h00;
      s_q         <= 3'd0;
      gnt_q       <= 8'h00;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      gnt_q       <= gnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign gnt       = gnt_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter.
// Instance a uses MAX_HOLD=4. Instance b uses MAX_HOLD=2 for the rotation test.
module tb_rr_mux8_arbiter;

  logic       clk = 1'b0;
  logic       rst_a, last_a, rst_b, last_b;
  logic [7:0] req_a, in_a, req_b, in_b;
  logic [2:0] s_a, s_b;
  logic [7:0] gnt_a, gnt_b;
  logic       out_a, ov_a, out_b, ov_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rr_mux8_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .last(last_a), .in(in_a),
    .s(s_a), .gnt(gnt_a), .out(out_a), .out_valid(ov_a)
  );

  rr_mux8_arbiter #(.MAX_HOLD(2)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .last(last_b), .in(in_b),
    .s(s_b), .gnt(gnt_b), .out(out_b), .out_valid(ov_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [2:0] es, input logic [7:0] eg,
                       input logic eov);
    tests_run++;
    if (gnt_a !== eg || ov_a !== eov || (eg != 8'h00 && s_a !== es)) begin
      tests_failed++;
      $display("FAIL %s: s=%0d gnt=%h ov=%b, expected s=%0d gnt=%h ov=%b",
               name, s_a, gnt_a, ov_a, es, eg, eov);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; req_a = 8'hFF; last_a = 1'b0; in_a = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (gnt_a !== 8'h00 || s_a !== 3'd0 || ov_a !== 1'b0 || out_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state: s=%0d gnt=%h ov=%b out=%b, expected all zero",
                 s_a, gnt_a, ov_a, out_a);
      end
    end
    rst_a = 1'b0;
    step();
    chk_a("reset_first_grant", 3'd0, 8'h01, 1'b0);
    req_a = 8'h00;
    step();
    chk_a("reset_release", 3'd0, 8'h00, 1'b0);
    step();
  endtask

  task automatic test_single_last();
    logic [2:0] bits;
    bits = 3'b101;
    req_a = 8'h08;
    step();
    chk_a("single_grant", 3'd3, 8'h08, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_a = {4'h0, bits[2 - i], 3'b000};
      last_a = (i == 2);
      step();
      chk_a("single_busy", 3'd3, (i == 2) ? 8'h00 : 8'h08, 1'b1);
      tests_run++;
      if (out_a !== bits[2 - i]) begin
        tests_failed++;
        $display("FAIL single_out[%0d]: out=%b, expected %b", i, out_a, bits[2 - i]);
      end
    end
    req_a = 8'h00; last_a = 1'b0;
    step();
    chk_a("single_idle", 3'd3, 8'h00, 1'b0);
    req_a = 8'h18;
    step();
    chk_a("single_ptr4", 3'd4, 8'h10, 1'b0);
    req_a = 8'h00;
    step();
    step();
  endtask

  task automatic test_early_drop();
    req_a = 8'h24;
    step();
    chk_a("drop_first_s5", 3'd5, 8'h20, 1'b0);
    step();
    chk_a("drop_xfer", 3'd5, 8'h20, 1'b1);
    req_a = 8'h04;
    step();
    chk_a("drop_release", 3'd5, 8'h00, 1'b0);
    step();
    chk_a("drop_next_s2", 3'd2, 8'h04, 1'b0);
    req_a = 8'h00;
    step();
    step();
  endtask

  task automatic test_hold_limit();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0; req_a = 8'h81;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i < 4)       chk_a("hold_g0", 3'd0, 8'h01, i != 0);
      else if (i == 4) chk_a("hold_idle0", 3'd0, 8'h00, 1'b1);
      else if (i < 9)  chk_a("hold_g7", 3'd7, 8'h80, i != 5);
      else if (i == 9) chk_a("hold_idle7", 3'd7, 8'h00, 1'b1);
      else             chk_a("hold_back0", 3'd0, 8'h01, 1'b0);
    end
    req_a = 8'h00;
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    req_a = 8'h40;
    step();
    chk_a("mid_grant_s6", 3'd6, 8'h40, 1'b0);
    step();
    chk_a("mid_xfer", 3'd6, 8'h40, 1'b1);
    rst_a = 1'b1;
    step();
    tests_run++;
    if (gnt_a !== 8'h00 || ov_a !== 1'b0 || s_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: s=%0d gnt=%h ov=%b, expected 0/00/0", s_a, gnt_a, ov_a);
    end
    rst_a = 1'b0; req_a = 8'h41;
    step();
    chk_a("mid_after_reset_s0", 3'd0, 8'h01, 1'b0);
    req_a = 8'h00;
    step();
  endtask

  task automatic test_rotation();
    rst_b = 1'b1; req_b = 8'hFF; in_b = 8'hFF; last_b = 1'b0;
    step();
    rst_b = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++) begin
        logic [7:0] eg;
        logic       eov;
        step();
        eg  = (c < 2) ? (8'h01 << (k % 8)) : 8'h00;
        eov = (c != 0);
        tests_run++;
        if (gnt_b !== eg || ov_b !== eov || s_b !== 3'(k % 8) || (eov && out_b !== 1'b1)) begin
          tests_failed++;
          $display("FAIL rotation[%0d,%0d]: s=%0d gnt=%h ov=%b out=%b, expected s=%0d gnt=%h ov=%b",
                   k, c, s_b, gnt_b, ov_b, out_b, k % 8, eg, eov);
        end
      end
    end
    req_b = 8'h00;
  endtask

  initial begin
    rst_b = 1'b1; req_b = 8'h00; in_b = 8'h00; last_b = 1'b0;
    test_reset();
    test_single_last();
    test_early_drop();
    test_hold_limit();
    test_reset_mid_grant();
    test_rotation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
